// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA/SVGA raster timing generator.
// Line order is active, front porch, sync, back porch; h=0 is the first
// visible pixel. The raster advances one pixel per clk with pix_ce=1, and all
// outputs are registered from the new position on that same edge.
// Also provides a pre-fetch coordinate LEAD pixels ahead of the beam.
// Optional: define VGA_TIMING_FRAME_CNT_EN to add frame_cnt and blink outputs.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int LEAD     = 2,
    parameter int CW       = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pix_ce,
    output logic          hsync,
    output logic          vsync,
    output logic          video_en,
    output logic [CW-1:0] xpos,
    output logic [CW-1:0] ypos,
    output logic          line_start,
    output logic          frame_start,
    output logic [CW-1:0] fetch_x,
    output logic [CW-1:0] fetch_y,
    output logic          fetch_en
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic [7:0]    frame_cnt,
    output logic          blink
`endif
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

    // One extra bit so h+LEAD cannot overflow before the modulo reduction.
    localparam logic [CW:0] H_TOT_W = (CW+1)'(H_TOTAL);
    localparam logic [CW:0] LEAD_W  = (CW+1)'(LEAD);

    logic [CW-1:0] h, v;
    logic [CW-1:0] h_nxt, v_nxt;
    logic [CW-1:0] fx_nxt, fy_nxt;
    logic [CW:0]   fsum;

    // next raster position, one pixel further on
    always_comb begin
        h_nxt = h + CW'(1);
        v_nxt = v;
        if (h == H_LAST) begin
            h_nxt = '0;
            v_nxt = (v == V_LAST) ? '0 : v + CW'(1);
        end
    end

    // fetch position LEAD pixels ahead of the new beam position; LEAD < H_TOTAL
    // so a single subtraction completes the modulo
    always_comb begin
        fsum   = {1'b0, h_nxt} + LEAD_W;
        fx_nxt = fsum[CW-1:0];
        fy_nxt = v_nxt;
        if (fsum >= H_TOT_W) begin
            fx_nxt = CW'(fsum - H_TOT_W);
            fy_nxt = (v_nxt == V_LAST) ? '0 : v_nxt + CW'(1);
        end
    end

    // raster state and registered outputs, updated from the new position
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h           <= H_LAST;
            v           <= V_LAST;
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            video_en    <= 1'b0;
            xpos        <= '0;
            ypos        <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            fetch_x     <= '0;
            fetch_y     <= '0;
            fetch_en    <= 1'b0;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            if (pix_ce) begin
                h           <= h_nxt;
                v           <= v_nxt;
                xpos        <= h_nxt;
                ypos        <= v_nxt;
                hsync       <= (h_nxt >= HS_BEG && h_nxt <= HS_END) ? HS_POL : ~HS_POL;
                vsync       <= (v_nxt >= VS_BEG && v_nxt <= VS_END) ? VS_POL : ~VS_POL;
                video_en    <= (h_nxt < H_ACT) && (v_nxt < V_ACT);
                fetch_x     <= fx_nxt;
                fetch_y     <= fy_nxt;
                fetch_en    <= (fx_nxt < H_ACT) && (fy_nxt < V_ACT);
                line_start  <= (h_nxt == '0);
                frame_start <= (h_nxt == '0) && (v_nxt == '0);
            end
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    // frame counter bumps on the edge that raises frame_start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            frame_cnt <= 8'd0;
        else if (pix_ce && h_nxt == '0 && v_nxt == '0)
            frame_cnt <= frame_cnt + 8'd1;
    end

    assign blink = frame_cnt[5];
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: four configurations (VGA default, tiny with large LEAD,
// SVGA 800x600, tiny with LEAD=0) run in lockstep from one pix_ce and are
// compared every clk against a model that derives each expected output from
// the number of pixel strobes since reset.
`timescale 1ns/1ps
module tb_vga_timing_gen;
    localparam int NI = 4;
    localparam int HA  [NI] = '{640, 16, 800, 10};
    localparam int HF  [NI] = '{16,  2,  40,  1};
    localparam int HS  [NI] = '{96,  3,  128, 2};
    localparam int HB  [NI] = '{48,  3,  88,  3};
    localparam int VA  [NI] = '{480, 10, 600, 6};
    localparam int VF  [NI] = '{10,  2,  1,   1};
    localparam int VS  [NI] = '{2,   2,  4,   1};
    localparam int VB  [NI] = '{33,  3,  23,  2};
    localparam bit HP  [NI] = '{1'b0, 1'b0, 1'b1, 1'b1};
    localparam bit VP  [NI] = '{1'b0, 1'b1, 1'b1, 1'b0};
    localparam int LD  [NI] = '{2,   15, 2,   0};
    localparam int CWS [NI] = '{10,  5,  11,  4};

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        ve;
        logic [11:0] x;
        logic [11:0] y;
        logic        ls;
        logic        fs;
        logic [11:0] fx;
        logic [11:0] fy;
        logic        fe;
        logic [7:0]  fc;
        logic        bl;
    } obs_t;

    logic clk, rst_n, pix_ce;
    obs_t ob [NI];

    int     checks = 0;
    int     errors = 0;
    longint n = 0;        // pixel strobes since reset
    bit     stepped = 0;  // last edge carried a strobe
    int     cyc = 0;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        logic [CWS[g]-1:0] x, y, fx, fy;
        logic hs, vs, ve, ls, fs, fe;
        logic [7:0] fc;
        logic bl;
        vga_timing_gen #(
            .H_ACTIVE(HA[g]), .H_FP(HF[g]), .H_SYNC(HS[g]), .H_BP(HB[g]),
            .V_ACTIVE(VA[g]), .V_FP(VF[g]), .V_SYNC(VS[g]), .V_BP(VB[g]),
            .HS_POL(HP[g]), .VS_POL(VP[g]), .LEAD(LD[g]), .CW(CWS[g])
        ) u_dut (
            .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce),
            .hsync(hs), .vsync(vs), .video_en(ve),
            .xpos(x), .ypos(y),
            .line_start(ls), .frame_start(fs),
            .fetch_x(fx), .fetch_y(fy), .fetch_en(fe)
`ifdef VGA_TIMING_FRAME_CNT_EN
            , .frame_cnt(fc), .blink(bl)
`endif
        );
`ifndef VGA_TIMING_FRAME_CNT_EN
        assign fc = 8'd0;
        assign bl = 1'b0;
`endif
        assign ob[g] = {hs, vs, ve, 12'(x), 12'(y), ls, fs, 12'(fx), 12'(fy), fe, fc, bl};
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Expected outputs of config i after cnt strobes; pixel index p = cnt-1.
    function automatic obs_t model(int i, longint cnt, bit stp);
        int     ht, vt, h, v, fxx, fyy;
        longint p, q;
        obs_t   e;
        ht = HA[i] + HF[i] + HS[i] + HB[i];
        vt = VA[i] + VF[i] + VS[i] + VB[i];
        e = '0;
        e.hs = ~HP[i];
        e.vs = ~VP[i];
        if (cnt == 0) return e;
        p   = cnt - 1;
        h   = int'(p % ht);
        v   = int'((p / ht) % vt);
        q   = p + LD[i];
        fxx = int'(q % ht);
        fyy = int'((q / ht) % vt);
        e.x  = 12'(h);
        e.y  = 12'(v);
        e.ve = (h < HA[i]) && (v < VA[i]);
        e.hs = (h >= HA[i] + HF[i] && h < HA[i] + HF[i] + HS[i]) ? HP[i] : ~HP[i];
        e.vs = (v >= VA[i] + VF[i] && v < VA[i] + VF[i] + VS[i]) ? VP[i] : ~VP[i];
        e.fx = 12'(fxx);
        e.fy = 12'(fyy);
        e.fe = (fxx < HA[i]) && (fyy < VA[i]);
        e.ls = stp && (h == 0);
        e.fs = stp && (h == 0) && (v == 0);
`ifdef VGA_TIMING_FRAME_CNT_EN
        e.fc = 8'(p / (ht * vt) + 1);
        e.bl = e.fc[5];
`endif
        return e;
    endfunction

    task automatic tick(input bit ce);
        pix_ce = ce;
        @(posedge clk);
        cyc++;
        if (ce) n++;
        stepped = ce;
        #1;
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        n = 0;
        stepped = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        obs_t e;
        rst_n = 1'b0;
        pix_ce = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            e = model(i, 0, 1'b0);
            checks++;
            if (ob[i] !== e) begin
                errors++;
                $display("FAIL reset_in[%0d] act=%h exp=%h", i, ob[i], e);
            end
        end
        #2 rst_n = 1'b1;
        tick(1'b0);
        tick(1'b0);
        for (int i = 0; i < NI; i++) begin
            e = model(i, n, stepped);
            checks++;
            if (ob[i] !== e) begin
                errors++;
                $display("FAIL reset_hold[%0d] act=%h exp=%h", i, ob[i], e);
            end
        end
    endtask

    task automatic test_first_line();
        obs_t e;
        int fall_n = -1, rise_n = -1, last_ls = -1, nper = 0, per_bad = 0;
        bit prev_hs = 1'b1;
        for (int k = 0; k < 1700; k++) begin
            tick(1'b1);
            for (int i = 0; i < NI; i++) begin
                e = model(i, n, stepped);
                checks++;
                if (ob[i] !== e) begin
                    errors++;
                    $display("FAIL line[%0d] n=%0d act=%h exp=%h", i, n, ob[i], e);
                end
            end
            if (n == 1) begin
                checks++;
                if ({ob[0].x, ob[0].y, ob[0].ve, ob[0].ls, ob[0].fs} !== {12'd0, 12'd0, 3'b111}) begin
                    errors++;
                    $display("FAIL first_edge act=%h/%h/%b%b%b exp=0/0/111",
                             ob[0].x, ob[0].y, ob[0].ve, ob[0].ls, ob[0].fs);
                end
            end
            if (n == 2) begin
                checks++;
                if ({ob[0].ls, ob[0].fs} !== 2'b00) begin
                    errors++;
                    $display("FAIL start_width act=%b%b exp=00", ob[0].ls, ob[0].fs);
                end
            end
            if (prev_hs && !ob[0].hs && fall_n < 0) fall_n = int'(n);
            if (!prev_hs && ob[0].hs && rise_n < 0) rise_n = int'(n);
            prev_hs = ob[0].hs;
            if (ob[0].ls) begin
                if (last_ls >= 0) begin
                    nper++;
                    if (cyc - last_ls != 800) per_bad++;
                end
                last_ls = cyc;
            end
        end
        checks++;
        if (fall_n != 657) begin
            errors++;
            $display("FAIL hsync_fall act_strobe=%0d exp=657", fall_n);
        end
        checks++;
        if (rise_n != 753) begin
            errors++;
            $display("FAIL hsync_rise act_strobe=%0d exp=753", rise_n);
        end
        checks++;
        if (nper != 2 || per_bad != 0) begin
            errors++;
            $display("FAIL line_period periods=%0d bad=%0d exp=2/0", nper, per_bad);
        end
    endtask

    task automatic test_lead();
        obs_t e;
        do_reset();
        while (n < 8799) begin
            tick(1'b1);
            for (int i = 0; i < NI; i++) begin
                e = model(i, n, stepped);
                checks++;
                if (ob[i] !== e) begin
                    errors++;
                    $display("FAIL lead[%0d] n=%0d act=%h exp=%h", i, n, ob[i], e);
                end
            end
            if (n == 225) begin
                checks++;
                if ({ob[1].fx, ob[1].fy, ob[1].fe} !== {12'd23, 12'd9, 1'b0}) begin
                    errors++;
                    $display("FAIL lead_small_blank act=%0d/%0d/%b exp=23/9/0", ob[1].fx, ob[1].fy, ob[1].fe);
                end
            end
            if (n == 408) begin
                checks++;
                if ({ob[1].fx, ob[1].fy, ob[1].fe} !== {12'd14, 12'd0, 1'b1}) begin
                    errors++;
                    $display("FAIL lead_small_wrap act=%0d/%0d/%b exp=14/0/1", ob[1].fx, ob[1].fy, ob[1].fe);
                end
            end
            if (n == 639) begin
                checks++;
                if ({ob[0].fx, ob[0].fe} !== {12'd640, 1'b0}) begin
                    errors++;
                    $display("FAIL lead_h638 act=%0d/%b exp=640/0", ob[0].fx, ob[0].fe);
                end
            end
        end
        checks++;
        if ({ob[0].x, ob[0].y, ob[0].fx, ob[0].fy, ob[0].fe} !== {12'd798, 12'd10, 12'd0, 12'd11, 1'b1}) begin
            errors++;
            $display("FAIL lead_h798 act=%0d,%0d->%0d/%0d/%b exp=798,10->0/11/1",
                     ob[0].x, ob[0].y, ob[0].fx, ob[0].fy, ob[0].fe);
        end
    endtask

    task automatic test_ce_div();
        obs_t e;
        int last_fs1 = -1, last_fs3 = -1, np1 = 0, np3 = 0, bad = 0;
        do_reset();
        for (int k = 0; k < 5000; k++) begin
            tick(k % 4 == 3);
            for (int i = 0; i < NI; i++) begin
                e = model(i, n, stepped);
                checks++;
                if (ob[i] !== e) begin
                    errors++;
                    $display("FAIL cediv[%0d] n=%0d act=%h exp=%h", i, n, ob[i], e);
                end
            end
            if (ob[1].fs) begin
                if (last_fs1 >= 0) begin np1++; if (cyc - last_fs1 != 4 * 408) bad++; end
                last_fs1 = cyc;
            end
            if (ob[3].fs) begin
                if (last_fs3 >= 0) begin np3++; if (cyc - last_fs3 != 4 * 160) bad++; end
                last_fs3 = cyc;
            end
        end
        checks++;
        if (np1 < 2 || np3 < 6 || bad != 0) begin
            errors++;
            $display("FAIL frame_period periods=%0d/%0d bad=%0d exp>=2/>=6 bad=0", np1, np3, bad);
        end
    endtask

    task automatic test_random();
        obs_t e;
        for (int k = 0; k < 4000; k++) begin
            tick($urandom_range(0, 2) != 0);
            for (int i = 0; i < NI; i++) begin
                e = model(i, n, stepped);
                checks++;
                if (ob[i] !== e) begin
                    errors++;
                    $display("FAIL random[%0d] n=%0d act=%h exp=%h", i, n, ob[i], e);
                end
            end
        end
    endtask

    task automatic test_midreset();
        obs_t e;
        for (int k = 0; k < 300 + int'($urandom_range(0, 50)); k++) tick(1'b1);
        #2;
        rst_n = 1'b0;
        n = 0;
        stepped = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            e = model(i, 0, 1'b0);
            checks++;
            if (ob[i] !== e) begin
                errors++;
                $display("FAIL async_reset[%0d] act=%h exp=%h", i, ob[i], e);
            end
        end
        #1 rst_n = 1'b1;
        tick(1'b0);
        tick(1'b1);
        for (int i = 0; i < NI; i++) begin
            e = model(i, n, stepped);
            checks++;
            if (ob[i] !== e) begin
                errors++;
                $display("FAIL after_reset[%0d] act=%h exp=%h", i, ob[i], e);
            end
        end
        checks++;
        if ({ob[0].x, ob[0].y, ob[0].fs, ob[0].ls} !== {12'd0, 12'd0, 2'b11}) begin
            errors++;
            $display("FAIL restart act=%0d,%0d fs=%b ls=%b exp=0,0 fs=1 ls=1", ob[0].x, ob[0].y, ob[0].fs, ob[0].ls);
        end
`ifdef VGA_TIMING_FRAME_CNT_EN
        checks++;
        if (ob[0].fc !== 8'd1) begin
            errors++;
            $display("FAIL frame_cnt act=%0d exp=1", ob[0].fc);
        end
`endif
    endtask

    task automatic test_svga();
        obs_t e;
        int hi_cnt = 0, first_hi = -1, last_ls = -1, per = -1;
        do_reset();
        for (int k = 0; k < 1100; k++) begin
            tick(1'b1);
            e = model(2, n, stepped);
            checks++;
            if (ob[2] !== e) begin
                errors++;
                $display("FAIL svga n=%0d act=%h exp=%h", n, ob[2], e);
            end
            if (n <= 1056 && ob[2].hs) begin
                hi_cnt++;
                if (first_hi < 0) first_hi = int'(n);
            end
            if (ob[2].ls) begin
                if (last_ls >= 0 && per < 0) per = cyc - last_ls;
                last_ls = cyc;
            end
        end
        checks++;
        if (hi_cnt != 128 || first_hi != 841) begin
            errors++;
            $display("FAIL svga_hsync act=%0d from %0d exp=128 from 841", hi_cnt, first_hi);
        end
        checks++;
        if (per != 1056) begin
            errors++;
            $display("FAIL svga_line_period act=%0d exp=1056", per);
        end
    endtask

    initial begin
        pix_ce = 1'b0;
        rst_n  = 1'b0;
        test_reset();
        test_first_line();
        test_lead();
        test_ce_div();
        test_random();
        test_midreset();
        test_svga();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
